// File: rtl/sparse_pkg.sv
// Shared types and helpers for the sparse dot-product engine.
// Holds the join state encoding and the saturating accumulate step.
package sparse_pkg;

    localparam int DEF_IDX_W  = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_CNT_W  = 9;
    localparam int SAT_W      = 64;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN_A,
        ST_DRAIN_B,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_t;

    // Operands arrive sign-extended to SAT_W; w is the live accumulator width.
    function automatic sat_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        logic signed [SAT_W:0] one;
        sat_t r;
        one = '0;
        one[0] = 1'b1;
        s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi = (one << (w - 1)) - one;
        lo = -hi - one;
        r.sum = s[SAT_W-1:0];
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi[SAT_W-1:0];
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo[SAT_W-1:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sparse_dot_engine_if.sv
// Stream and result handshake bundle of the sparse dot-product engine.
// The engine takes the slave side; the unpacker/packer take master.
interface sparse_dot_engine_if #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 9
);
    logic                     a_valid;
    logic                     a_ready;
    logic        [IDX_W-1:0]  a_idx;
    logic signed [DATA_W-1:0] a_val;
    logic                     a_last;
    logic                     b_valid;
    logic                     b_ready;
    logic        [IDX_W-1:0]  b_idx;
    logic signed [DATA_W-1:0] b_val;
    logic                     b_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic        [CNT_W-1:0]  out_matches;
    logic                     out_ovf;
    logic                     out_err;

    modport slave (
        input  a_valid, a_idx, a_val, a_last,
        input  b_valid, b_idx, b_val, b_last,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_sum, out_matches, out_ovf, out_err
    );

    modport master (
        output a_valid, a_idx, a_val, a_last,
        output b_valid, b_idx, b_val, b_last,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_sum, out_matches, out_ovf, out_err
    );
endinterface

// File: rtl/sparse_dot_engine_mac_pipe.sv
// Two-stage multiply / saturating-accumulate pipe.
// Product registered first, accumulator updated the cycle after.
module mac_pipe
    import sparse_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod_q;
    logic                 pv_q;
    sat_t                 r;

    always_comb begin
        r = sat_add({{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc},
                    {{(SAT_W-PW){prod_q[PW-1]}}, prod_q},
                    ACC_W);
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            pv_q   <= in_valid;
            prod_q <= PW'(a) * PW'(b);
            if (pv_q) begin
                acc <= r.sum[ACC_W-1:0];
                ovf <= ovf | r.ovf;
            end
        end
    end
endmodule

// File: rtl/sparse_dot_engine.sv
// Merge-join sparse dot product: joins two index-sorted streams,
// multiplies matching values and holds the saturated sum for the packer.
module sparse_dot_engine
    import sparse_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic           clk,
    input logic           reset,
    sparse_dot_engine_if.slave io
);
    state_t            state_q;
    state_t            state_d;
    logic              fl_q;
    logic              a_rdy;
    logic              b_rdy;
    logic              issue;
    logic              accept;
    logic [IDX_W-1:0]  a_prev_q;
    logic [IDX_W-1:0]  b_prev_q;
    logic              a_seen_q;
    logic              b_seen_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    assign accept = io.out_valid && io.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fl_q    <= (state_q == ST_FLUSH) && !fl_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (a_rdy && io.a_last && b_rdy && io.b_last)
                    state_d = ST_FLUSH;
                else if (a_rdy && io.a_last)
                    state_d = ST_DRAIN_B;
                else if (b_rdy && io.b_last)
                    state_d = ST_DRAIN_A;
            end
            ST_DRAIN_A: if (a_rdy && io.a_last) state_d = ST_FLUSH;
            ST_DRAIN_B: if (b_rdy && io.b_last) state_d = ST_FLUSH;
            ST_FLUSH:   if (fl_q) state_d = ST_DONE;
            ST_DONE:    if (accept) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Readies depend only on heads and state, never on out_ready.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (io.a_valid && io.b_valid) begin
                    unique case (1'b1)
                        (io.a_idx == io.b_idx): begin
                            a_rdy = 1'b1;
                            b_rdy = 1'b1;
                            issue = 1'b1;
                        end
                        (io.a_idx < io.b_idx): a_rdy = 1'b1;
                        default:               b_rdy = 1'b1;
                    endcase
                end
            end
            ST_DRAIN_A: a_rdy = io.a_valid;
            ST_DRAIN_B: b_rdy = io.b_valid;
            default: ;
        endcase
        if (!reset) begin
            a_rdy = 1'b0;
            b_rdy = 1'b0;
            issue = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            a_prev_q <= '0;
            b_prev_q <= '0;
            a_seen_q <= 1'b0;
            b_seen_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (a_rdy) begin
                a_prev_q <= io.a_idx;
                a_seen_q <= 1'b1;
                if (a_seen_q && io.a_idx <= a_prev_q) err_q <= 1'b1;
            end
            if (b_rdy) begin
                b_prev_q <= io.b_idx;
                b_seen_q <= 1'b1;
                if (b_seen_q && io.b_idx <= b_prev_q) err_q <= 1'b1;
            end
            if (issue && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    mac_pipe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .in_valid(issue),
        .a       (io.a_val),
        .b       (io.b_val),
        .acc     (io.out_sum),
        .ovf     (io.out_ovf)
    );

    assign io.a_ready     = a_rdy;
    assign io.b_ready     = b_rdy;
    assign io.out_valid   = (state_q == ST_DONE);
    assign io.out_matches = cnt_q;
    assign io.out_err     = err_q;
endmodule

// File: tb/tb_sparse_dot_engine.sv
// Randomised bench for sparse_dot_engine against a nested-loop
// dot-product model with clamped accumulation.
module tb_sparse_dot_engine;
    localparam int IW = 8;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ai[$];
    int   av[$];
    int   bi[$];
    int   bv[$];

    always #5 clk = ~clk;

    sparse_dot_engine_if #(
        .IDX_W(IW), .DATA_W(DW), .ACC_W(AW), .CNT_W(CW)
    ) bus ();

    sparse_dot_engine #(
        .IDX_W(IW), .DATA_W(DW), .ACC_W(AW), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sum_now();
        return longint'($signed(bus.out_sum));
    endfunction

    task automatic model(output longint s, output int m,
                         output bit ovf, output bit err);
        longint hi = (longint'(1) <<< (AW - 1)) - 1;
        longint lo = -hi - 1;
        s = 0; m = 0; ovf = 0; err = 0;
        foreach (ai[i])
            foreach (bi[j])
                if (ai[i] == bi[j]) begin
                    m++;
                    s += longint'(av[i]) * longint'(bv[j]);
                    if (s > hi) begin s = hi; ovf = 1; end
                    if (s < lo) begin s = lo; ovf = 1; end
                end
        for (int i = 1; i < ai.size(); i++) if (ai[i] <= ai[i-1]) err = 1;
        for (int i = 1; i < bi.size(); i++) if (bi[i] <= bi[i-1]) err = 1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.b_valid = 0;
        bus.a_last = 0;  bus.b_last = 0;
        bus.a_idx = '0;  bus.b_idx = '0;
        bus.a_val = '0;  bus.b_val = '0;
    endtask

    task automatic run_case(input string tag, input int gap, input int hold);
        int pa = 0, pb = 0, cyc = 0, lat, em;
        bit ra, rb, eo, ee;
        longint es;
        model(es, em, eo, ee);
        bus.out_ready = 0;
        while ((pa < ai.size() || pb < bi.size()) && cyc < 3000) begin
            @(negedge clk);
            bus.a_valid = (pa < ai.size()) && ($urandom_range(99) >= gap);
            bus.b_valid = (pb < bi.size()) && ($urandom_range(99) >= gap);
            if (pa < ai.size()) begin
                bus.a_idx = IW'(ai[pa]);
                bus.a_val = DW'(av[pa]);
                bus.a_last = (pa == ai.size() - 1);
            end
            if (pb < bi.size()) begin
                bus.b_idx = IW'(bi[pb]);
                bus.b_val = DW'(bv[pb]);
                bus.b_last = (pb == bi.size() - 1);
            end
            #1;
            ra = bus.a_valid && bus.a_ready;
            rb = bus.b_valid && bus.b_ready;
            @(posedge clk);
            if (ra) pa++;
            if (rb) pb++;
            cyc++;
        end
        chk({tag, "_consumed"}, longint'(cyc < 3000), 1);
        @(negedge clk);
        idle_inputs();
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        for (int k = 0; k < hold; k++) begin
            bus.a_valid = 1; bus.b_valid = 1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_sum"}, sum_now(), es);
            chk({tag, "_hold_rdy"}, {bus.a_ready, bus.b_ready}, 0);
            chk({tag, "_hold_vld"}, bus.out_valid, 1);
        end
        idle_inputs();
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_sum"}, sum_now(), es);
        chk({tag, "_matches"}, bus.out_matches, em);
        chk({tag, "_ovf"}, bus.out_ovf, eo);
        chk({tag, "_err"}, bus.out_err, ee);
        bus.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 0;
        chk({tag, "_clr_vld"}, bus.out_valid, 0);
        chk({tag, "_clr_flags"},
            {bus.out_matches, bus.out_ovf, bus.out_err}, 0);
        chk({tag, "_clr_sum"}, sum_now(), 0);
    endtask

    function automatic int rval(input bit big);
        if (big) return $urandom_range(1) ? 32767 : -32768;
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic gen_pair(input bit big);
        int ti[$], tv[$], n, idx;
        for (int s = 0; s < 2; s++) begin
            ti = {}; tv = {};
            n = 1 + $urandom_range(7);
            idx = $urandom_range(3);
            for (int k = 0; k < n; k++) begin
                ti.push_back(idx);
                tv.push_back(rval(big));
                idx += 1 + $urandom_range(2);
            end
            if (s == 0) begin ai = ti; av = tv; end
            else begin bi = ti; bv = tv; end
        end
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 0;
        bus.a_valid = 1; bus.b_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_rdy", {bus.a_ready, bus.b_ready}, 0);
        chk("rst_flags", {bus.out_matches, bus.out_ovf, bus.out_err}, 0);
        chk("rst_sum", sum_now(), 0);
        idle_inputs();
        reset = 1;

        ai = '{1, 4, 7}; av = '{3, -2, 5};
        bi = '{4, 7};    bv = '{6, 2};
        run_case("basic", 0, 0);

        ai = '{0, 2}; av = '{9, 9};
        bi = '{1, 3}; bv = '{9, 9};
        run_case("disjoint", 0, 0);

        ai = '{0, 1, 2}; av = '{32767, 32767, 32767};
        bi = '{0, 1, 2}; bv = '{32767, 32767, 32767};
        run_case("sat_pos", 0, 0);

        ai = '{0, 1, 2}; av = '{-32768, -32768, -32768};
        bi = '{0, 1, 2}; bv = '{32767, 32767, 32767};
        run_case("sat_neg", 0, 0);

        ai = '{5, 3}; av = '{1, 1};
        bi = '{9};    bv = '{1};
        run_case("order_a", 0, 0);

        ai = '{1};    av = '{2};
        bi = '{6, 2}; bv = '{3, 3};
        run_case("order_b", 0, 0);

        ai = '{0};    av = '{0};
        bi = '{3, 5}; bv = '{7, 7};
        run_case("empty", 0, 0);

        gen_pair(0);
        run_case("bp", 30, 10);

        for (int t = 0; t < 20; t++) begin
            gen_pair((t % 4) == 3);
            run_case($sformatf("rnd%0d", t), 35, $urandom_range(3));
        end

        @(negedge clk);
        bus.a_valid = 1; bus.b_valid = 1;
        bus.a_idx = 1; bus.b_idx = 1; bus.a_val = 7; bus.b_val = 7;
        @(posedge clk);
        @(negedge clk);
        bus.a_idx = 2; bus.b_idx = 2;
        @(posedge clk);
        @(negedge clk);
        bus.a_idx = 3; bus.b_idx = 3;
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_vld", bus.out_valid, 0);
        chk("mid_rst_rdy", {bus.a_ready, bus.b_ready}, 0);
        chk("mid_rst_flags",
            {bus.out_matches, bus.out_ovf, bus.out_err}, 0);
        chk("mid_rst_sum", sum_now(), 0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset = 1;

        ai = '{2}; av = '{4};
        bi = '{2}; bv = '{5};
        run_case("post_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparse_dot_engine.md
# sparse_dot_engine

Parametrised merge-join multiply-accumulate engine for the sparse matrix coprocessor. It computes the dot product of one sparse row (A) and one sparse column (B). Each arrives as a stream of (index, value) pairs sorted by strictly ascending index. It matches equal indices, multiplies their signed fixed-point values, and accumulates with saturation. It sits between the host-link unpacker and the result packer, and replaces the single-element index comparator with a streaming, pipelined unit.

## Interface
- IDX_W, default 8: index width.
- DATA_W, default 16: signed value width.
- ACC_W, default 40: signed accumulator width; must be ≥ 2·DATA_W.
- CNT_W, default 9: match-counter width.
- clk, input, 1: sole clock; everything is on the rising edge.
- reset, input, 1: synchronous, active-low.
- a_valid / b_valid, input, 1: stream head valid.
- a_ready / b_ready, output, 1: head consumed this cycle.
- a_idx / b_idx, input, IDX_W: element index.
- a_val / b_val, input, DATA_W: element value, signed.
- a_last / b_last, input, 1: final element of the vector.
- out_valid, output, 1: result available.
- out_ready, input, 1: result accepted.
- out_sum, output, ACC_W: saturated dot product.
- out_matches, output, CNT_W: number of index matches (saturating).
- out_ovf, output, 1: accumulator saturated at least once.
- out_err, output, 1: an input vector violated strictly ascending index order.

## Operation
- States:
  - RUN: both vectors are open.
  - DRAIN_A: B is finished; discard A until a_last.
  - DRAIN_B: A is finished; discard B until b_last.
  - FLUSH: wait for the pipeline to empty.
  - DONE: hold the result.
- RUN, when both heads are valid:
  - a_idx == b_idx: consume both and issue a product.
  - a_idx < b_idx: consume A only.
  - a_idx > b_idx: consume B only.
- RUN, when either head is invalid: consume nothing.
- Leaving RUN:
  - A consumed with a_last and B not at its last: go to DRAIN_B.
  - Symmetric case for B: go to DRAIN_A.
  - Both last elements consumed in the same cycle: go to FLUSH.
- DRAIN_x: consume x whenever it is valid. The other ready stays 0. Go to FLUSH when the last element is consumed.
- FLUSH: lasts exactly 2 cycles, then DONE.
- DONE: out_valid = 1. On out_valid && out_ready, clear the accumulator, counter and flags, then go to RUN.
- Input readies are 0 in FLUSH and DONE.
- Arithmetic:
  - Product is DATA_W×DATA_W signed, giving 2·DATA_W bits, sign-extended to ACC_W.
  - Sum saturates to the most positive or most negative ACC_W value. Saturation sets out_ovf, which is sticky until result acceptance.
- Order check: per stream, register the last consumed index. A consumed index ≤ that register sets sticky out_err. Processing continues regardless. The register is cleared at the start of each vector.
- Empty vector (first element has last = 1, value 0): legal and treated as a normal element.
- Reset (reset == 0):
  - State returns to RUN; pipeline and accumulator are cleared.
  - Outputs: readies 0, out_valid 0, out_sum 0, out_matches 0, out_ovf 0, out_err 0.
  - A reset mid-vector discards the partial result.

## Timing
- Readies are combinational from the heads and state. There is no combinational path from out_ready to the input readies.
- Pipeline:
  - Compare/consume in cycle N.
  - Product register at N+1.
  - Accumulator update at N+2.
- One match per cycle sustained.
- out_valid rises 3 cycles after the cycle that consumes the final element.
- The result holds stable while out_valid && !out_ready.
- The earliest next consumption is the cycle after acceptance.
- Stall on either input (valid = 0) inserts a bubble; no data is lost.

## Structure
- Package sparse_pkg holds:
  - the state enum;
  - IDX_W/DATA_W/ACC_W defaults;
  - a saturate-add function (ACC_W signed, returns sum and ovf).
- One sub-module, mac_pipe: product register, sign-extend and saturating accumulate, with a clear input.
- The join FSM, order checker and output holding stay in sparse_dot_engine.

## Test plan
- Basic match:
  - Stimulus: A = {(1,3),(4,−2),(7,5)}, B = {(4,6),(7,2)}.
  - Response: out_sum = −2, out_matches = 2, out_ovf = 0, out_err = 0, out_valid exactly 3 cycles after the last consume.
- Disjoint vectors:
  - Stimulus: A = {(0,9),(2,9)}, B = {(1,9),(3,9)}.
  - Response: out_sum = 0, out_matches = 0, DRAIN_B traversed.
- Saturation:
  - Stimulus: DATA_W = 16, ACC_W = 32; 3 matches of (0x7FFF × 0x7FFF).
  - Response: out_sum = 0x7FFFFFFF, out_ovf = 1.
- Ordering error:
  - Stimulus: A indices {5,3}.
  - Response: out_err = 1, vector completes normally, flag clears after acceptance.
- Backpressure and bubbles:
  - Stimulus: random a_valid/b_valid gaps, out_ready held low 10 cycles.
  - Response: result equals the reference model; output stable while held; readies 0 in DONE.
- Reset mid-vector:
  - Stimulus: assert reset after 2 matches, then a fresh vector pair A = {(2,4)}, B = {(2,5)}.
  - Response: all outputs 0 during reset; next result 20 with out_matches = 1.
